// File: rtl/gpr_file_pkg.sv
// gpr_file_pkg
//   Shared constants for the general-purpose register file: word and
//   register-address widths, the write-enable encoding, the flag-register
//   operation codes and the address of the register that doubles as the
//   condition-flag register.
package gpr_file_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    localparam logic WR_EN  = 1'b1;
    localparam logic WR_DIS = 1'b0;

    localparam logic [1:0] FLAG_OP_DIS        = 2'b00;
    localparam logic [1:0] FLAG_OP_SET        = 2'b01;
    localparam logic [1:0] FLAG_OP_SET_AND_WR = 2'b10;

    localparam logic [REG_ADDR_W-1:0] REG_ADDR_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_ADDR_FLAG = 5'd30;

endpackage

// File: rtl/gpr_file.sv
// gpr_file
//   32 x 32-bit general-purpose register file with two combinational read
//   ports, one synchronous write port and a dedicated flag write path into
//   register 30 (the condition-flag register).
//
//   Ports
//     clk     in   1   clock, all writes on the rising edge
//     reset   in   1   asynchronous active-low clear of all registers
//     WE      in   1   write enable for the Din/AWr port
//     FlagOp  in   2   flag operation: DIS / SET / SET_AND_WR (2'b11 = DIS)
//     A1      in   5   read address, port 1
//     A2      in   5   read address, port 2
//     AWr     in   5   write address
//     Din     in  32   write data
//     NFlag   in  32   new flag value
//     RD1     out 32   regs[A1]
//     RD2     out 32   regs[A2]
//     Flag    out 32   regs[30]
module gpr_file
    import gpr_file_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  WE,
    input  logic [1:0]            FlagOp,
    input  logic [REG_ADDR_W-1:0] A1,
    input  logic [REG_ADDR_W-1:0] A2,
    input  logic [REG_ADDR_W-1:0] AWr,
    input  logic [WORD_W-1:0]     Din,
    input  logic [WORD_W-1:0]     NFlag,
    output logic [WORD_W-1:0]     RD1,
    output logic [WORD_W-1:0]     RD2,
    output logic [WORD_W-1:0]     Flag
);

    logic [WORD_W-1:0] regs [NUM_REGS];

    logic data_wr;
    logic flag_wr;

    // A plain SET claims the edge for the flag path only; SET_AND_WR still
    // lets the data port write. The reserved code 2'b11 falls out as DIS.
    assign flag_wr = (FlagOp == FLAG_OP_SET) || (FlagOp == FLAG_OP_SET_AND_WR);
    assign data_wr = (WE == WR_EN) && (FlagOp != FLAG_OP_SET) && (AWr != REG_ADDR_ZERO);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (data_wr) begin
                regs[AWr] <= Din;
            end
            // Issued after the data write so that NFlag wins when AWr
            // also targets the flag register on the same edge.
            if (flag_wr) begin
                regs[REG_ADDR_FLAG] <= NFlag;
            end
        end
    end

    // Register 0 is hard-wired to zero on the read side; no bypass from the
    // write port, so a same-cycle read sees the old contents.
    assign RD1  = (A1 == REG_ADDR_ZERO) ? '0 : regs[A1];
    assign RD2  = (A2 == REG_ADDR_ZERO) ? '0 : regs[A2];
    assign Flag = regs[REG_ADDR_FLAG];

endmodule

// File: tb/tb_gpr_file.sv
module tb_gpr_file;
    import gpr_file_pkg::*;

    logic        clk;
    logic        reset;
    logic        WE;
    logic [1:0]  FlagOp;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [4:0]  AWr;
    logic [31:0] Din;
    logic [31:0] NFlag;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [31:0] Flag;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    gpr_file dut (
        .clk    (clk),
        .reset  (reset),
        .WE     (WE),
        .FlagOp (FlagOp),
        .A1     (A1),
        .A2     (A2),
        .AWr    (AWr),
        .Din    (Din),
        .NFlag  (NFlag),
        .RD1    (RD1),
        .RD2    (RD2),
        .Flag   (Flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %h but scoreboard is empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset  = 1'b0;
        WE     = WR_DIS;
        FlagOp = FLAG_OP_DIS;
        A1     = '0;
        A2     = '0;
        AWr    = '0;
        Din    = '0;
        NFlag  = '0;

        // Reset sweep: every address reads zero while reset is held.
        #2;
        for (int i = 0; i < 32; i++) begin
            A1 = 5'(i);
            A2 = 5'(31 - i);
            push(32'h0); push(32'h0); push(32'h0);
            #1;
            check("reset_rd1", RD1);
            check("reset_rd2", RD2);
            check("reset_flag", Flag);
        end

        @(negedge clk);
        reset = 1'b1;

        // Basic write
        @(negedge clk);
        WE = WR_EN; FlagOp = FLAG_OP_DIS; AWr = 5'd20; Din = 32'hfedc_1234; A1 = 5'd20;
        push(32'hfedc_1234);
        tick();
        check("write_en", RD1);

        // Write disabled
        @(negedge clk);
        WE = WR_DIS; Din = 32'h0123_4567;
        push(32'hfedc_1234);
        tick();
        check("write_dis", RD1);

        // Write to register 0 ignored
        @(negedge clk);
        WE = WR_EN; AWr = 5'd0; Din = 32'h2345_6789; A1 = 5'd0;
        push(32'h0);
        tick();
        check("write_r0", RD1);

        // Read during write returns old value until the edge
        @(negedge clk);
        WE = WR_EN; AWr = 5'd20; Din = 32'h1111_2222; A1 = 5'd20;
        push(32'hfedc_1234);
        #1;
        check("rdw_old", RD1);
        push(32'h1111_2222);
        tick();
        check("rdw_new", RD1);

        // Flag set
        @(negedge clk);
        WE = WR_DIS; FlagOp = FLAG_OP_SET; NFlag = 32'h1234_cdef;
        push(32'h1234_cdef);
        tick();
        check("flag_set", Flag);

        // Flag hold
        @(negedge clk);
        FlagOp = FLAG_OP_DIS; NFlag = 32'h0123_4567;
        push(32'h1234_cdef);
        tick();
        check("flag_hold", Flag);

        // SET suppresses data write even with WE
        @(negedge clk);
        WE = WR_EN; FlagOp = FLAG_OP_SET; AWr = 5'd22; Din = 32'hdead_beef;
        NFlag = 32'h0f0f_0f0f; A2 = 5'd22;
        push(32'h0); push(32'h0f0f_0f0f);
        tick();
        check("set_blocks_wr", RD2);
        check("set_flag", Flag);

        // Set-and-write
        @(negedge clk);
        WE = WR_EN; FlagOp = FLAG_OP_SET_AND_WR; AWr = 5'd21; Din = 32'h9876_5432;
        NFlag = 32'h1212_3434; A1 = 5'd21;
        push(32'h9876_5432); push(32'h1212_3434);
        tick();
        check("sw_data", RD1);
        check("sw_flag", Flag);

        // Set-and-write with WE low: flag only
        @(negedge clk);
        WE = WR_DIS; FlagOp = FLAG_OP_SET_AND_WR; AWr = 5'd23; Din = 32'h3333_4444;
        NFlag = 32'h5656_7878; A2 = 5'd23;
        push(32'h0); push(32'h5656_7878);
        tick();
        check("sw_we0_data", RD2);
        check("sw_we0_flag", Flag);

        // DIS with AWr = 30 writes Din into the flag register
        @(negedge clk);
        WE = WR_EN; FlagOp = FLAG_OP_DIS; AWr = 5'd30; Din = 32'hcafe_f00d; NFlag = 32'h0;
        push(32'hcafe_f00d);
        tick();
        check("dis_wr_flag", Flag);

        // Reserved FlagOp behaves as DIS
        @(negedge clk);
        WE = WR_EN; FlagOp = 2'b11; AWr = 5'd30; Din = 32'h0bad_c0de; NFlag = 32'h7777_7777;
        push(32'h0bad_c0de);
        tick();
        check("rsvd_op", Flag);

        // Collision: NFlag wins
        @(negedge clk);
        WE = WR_EN; FlagOp = FLAG_OP_SET_AND_WR; AWr = 5'd30; Din = 32'hAAAA_AAAA;
        NFlag = 32'h5555_5555; A1 = 5'd30;
        push(32'h5555_5555); push(32'h5555_5555);
        tick();
        check("collision_flag", Flag);
        check("collision_rd1", RD1);

        // Reset mid-run clears immediately and overrides pending writes
        @(negedge clk);
        WE = WR_EN; FlagOp = FLAG_OP_SET_AND_WR; AWr = 5'd20; Din = 32'h4444_4444;
        NFlag = 32'h6666_6666; A1 = 5'd20; A2 = 5'd21;
        #1;
        reset = 1'b0;
        #1;
        push(32'h0); push(32'h0); push(32'h0);
        check("rst_async_rd1", RD1);
        check("rst_async_rd2", RD2);
        check("rst_async_flag", Flag);
        push(32'h0); push(32'h0);
        tick();
        check("rst_hold_rd1", RD1);
        check("rst_hold_flag", Flag);

        // Recovery after reset
        @(negedge clk);
        reset = 1'b1;
        WE = WR_EN; FlagOp = FLAG_OP_DIS; AWr = 5'd5; Din = 32'h1357_9bdf; A1 = 5'd5;
        push(32'h1357_9bdf); push(32'h0);
        tick();
        check("post_rst_wr", RD1);
        check("post_rst_flag", Flag);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
